// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// Holds the legacy 1001 defaults plus the length clamp and length-mask functions.
package seq_det_pkg;

  localparam logic [31:0] DEF_PATTERN_C = 32'h0000_0009;
  localparam int unsigned DEF_LEN_C     = 32'd4;
  localparam logic        DEF_OVERLAP_C = 1'b1;

  // A zero length would match on no history at all, so it is promoted to one.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    int unsigned r;
    if (len == 32'd0) begin
      r = 32'd1;
    end else if (len > max_len) begin
      r = max_len;
    end else begin
      r = len;
    end
    return r;
  endfunction

  function automatic logic [31:0] len_mask(input int unsigned len);
    logic [31:0] m;
    if (len >= 32'd32) begin
      m = 32'hFFFF_FFFF;
    end else begin
      m = (32'd1 << len) - 32'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; a clear wins over a simultaneous increment.
module seq_det_match_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
// The saturating match counter is built only when SEQ_DETECTOR_CNT_EN is defined.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int unsigned        DEF_LEN     = DEF_LEN_C,
  parameter logic               DEF_OVERLAP = DEF_OVERLAP_C,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i,
  input  logic                         in_valid,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         y,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int unsigned   LW       = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] MAX_HIST = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE_H    = LW'(1);

  logic [MAX_LEN-1:0] win_q, win_d;
  logic [LW-1:0]      hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               y_q, y_d;
  logic [LW-1:0]      hist_inc_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               hit_s;

  assign mask_s = MAX_LEN'(len_mask(32'(len_q)));

  // Next-state: configuration load has priority and restarts the history.
  always_comb begin
    win_d      = win_q;
    hist_d     = hist_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    y_d        = 1'b0;
    hit_s      = 1'b0;
    hist_inc_s = hist_q;
    if (cfg_we) begin
      pat_d  = cfg_pattern;
      len_d  = LW'(clamp_len(32'(cfg_len), MAX_LEN));
      ovl_d  = cfg_overlap;
      hist_d = {LW{1'b0}};
    end else if (in_valid) begin
      win_d      = {win_q[MAX_LEN-2:0], i};
      hist_inc_s = (hist_q == MAX_HIST) ? hist_q : (hist_q + ONE_H);
      hit_s      = (hist_inc_s >= len_q) && ((win_d & mask_s) == (pat_q & mask_s));
      // Non-overlap consumes the matched bits by restarting the history.
      hist_d     = (hit_s && !ovl_q) ? {LW{1'b0}} : hist_inc_s;
      y_d        = hit_s;
    end else begin
      y_d = 1'b0;
    end
  end

  // Detector state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= {MAX_LEN{1'b0}};
      hist_q <= {LW{1'b0}};
      pat_q  <= DEF_PATTERN;
      len_q  <= LW'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      y_q    <= 1'b0;
    end else begin
      win_q  <= win_d;
      hist_q <= hist_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

`ifdef SEQ_DETECTOR_CNT_EN
  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (hit_s),
    .cnt (match_cnt)
  );
`else
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s = cnt_clr;
  assign match_cnt        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector against a bit-history reference model.
module tb_seq_detector;

  localparam int MAXL = 8;
  localparam int CW   = 2;

  logic          clk;
  logic          rst;
  logic          i;
  logic          in_valid;
  logic          cfg_we;
  logic [7:0]    cfg_pattern;
  logic [3:0]    cfg_len;
  logic          cfg_overlap;
  logic          cnt_clr;
  logic          y;
  logic [CW-1:0] match_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic          hq[$];
  int            hist_m;
  logic [7:0]    pat_m;
  int            len_m;
  logic          ovl_m;
  logic          exp_y;
  logic [CW-1:0] exp_cnt;

  seq_detector #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    hq.delete();
    for (int k = 0; k < MAXL; k++) hq.push_back(1'b0);
    hist_m  = 0;
    pat_m   = 8'b0000_1001;
    len_m   = 4;
    ovl_m   = 1'b1;
    exp_y   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic we, input logic [7:0] cp,
                            input logic [3:0] cl, input logic co, input logic clr);
    logic hit;
    hit   = 1'b0;
    exp_y = 1'b0;
    if (we) begin
      pat_m  = cp;
      len_m  = (cl == 0) ? 1 : ((int'(cl) > MAXL) ? MAXL : int'(cl));
      ovl_m  = co;
      hist_m = 0;
    end else if (v) begin
      hq.push_back(b);
      if (hq.size() > MAXL) void'(hq.pop_front());
      hist_m++;
      if (hist_m >= len_m) begin
        hit = 1'b1;
        for (int k = 0; k < len_m; k++)
          if (hq[hq.size() - 1 - k] != pat_m[k]) hit = 1'b0;
      end
      if (hit) begin
        exp_y = 1'b1;
        if (!ovl_m) hist_m = 0;
      end
    end
`ifdef SEQ_DETECTOR_CNT_EN
    if (clr) exp_cnt = '0;
    else if (hit && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
`endif
  endtask

  task automatic cycle(input logic v, input logic b, input logic we, input logic [7:0] cp,
                       input logic [3:0] cl, input logic co, input logic clr);
    in_valid = v; i = b; cfg_we = we; cfg_pattern = cp; cfg_len = cl;
    cfg_overlap = co; cnt_clr = clr;
    model_step(v, b, we, cp, cl, co, clr);
    @(posedge clk);
    #1;
    in_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic bit_in(input logic b);
    cycle(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cycle(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    in_valid = 1'b0; i = 1'b0; cfg_we = 1'b0; cfg_pattern = 8'h00;
    cfg_len = 4'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL reset_y: got %0b want 0", y); end
    total++;
    if (match_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_default_1001();
    logic [6:0] bits;
    int pulses;
    bits = 7'b1001001;
    pulses = 0;
    for (int k = 6; k >= 0; k--) begin
      bit_in(bits[k]);
      if (y === 1'b1) pulses++;
      total++;
      if (y !== exp_y) begin bad++; $display("FAIL dflt_y step %0d: got %0b want %0b", 6 - k, y, exp_y); end
    end
    total++;
    if (pulses != 2) begin bad++; $display("FAIL dflt_pulses: got %0d want 2", pulses); end
    total++;
`ifdef SEQ_DETECTOR_CNT_EN
    if (match_cnt !== 2'd2) begin bad++; $display("FAIL dflt_cnt: got %0d want 2", match_cnt); end
`else
    if (match_cnt !== 2'd0) begin bad++; $display("FAIL dflt_cnt: got %0d want 0", match_cnt); end
`endif
  endtask

  task automatic test_overlap_modes();
    logic [4:0] bits;
    int pulses;
    bits = 5'b10101;
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      load(8'h05, 4'd3, m[0]);
      pulses = 0;
      for (int k = 4; k >= 0; k--) begin
        bit_in(bits[k]);
        if (y === 1'b1) pulses++;
        total++;
        if (y !== exp_y) begin bad++; $display("FAIL ovl%0d_y step %0d: got %0b want %0b", m, 4 - k, y, exp_y); end
      end
      total++;
      if (pulses != (m == 1 ? 2 : 1)) begin bad++; $display("FAIL ovl%0d_pulses: got %0d want %0d", m, pulses, (m == 1 ? 2 : 1)); end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] p;
    int pulses;
    p = 8'hA5;
    do_reset();
    load(p, 4'd8, 1'b1);
    pulses = 0;
    for (int k = 7; k >= 0; k--) begin
      bit_in(p[k]);
      if (y === 1'b1) pulses++;
      total++;
      if (y !== exp_y) begin bad++; $display("FAIL gap_y bit %0d: got %0b want %0b", 7 - k, y, exp_y); end
      cycle(1'b0, ~p[k], 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
      if (y === 1'b1) pulses++;
      total++;
      if (y !== 1'b0) begin bad++; $display("FAIL gap_idle_y after bit %0d: got %0b want 0", 7 - k, y); end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_cfg_priority();
    logic [5:0] tail;
    do_reset();
    load(8'h05, 4'd3, 1'b1);
    bit_in(1'b1);
    bit_in(1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h05, 4'd3, 1'b1, 1'b0);
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL cfgpri_y: got %0b want 0", y); end
    tail = 6'b000101;
    for (int k = 2; k >= 0; k--) begin
      bit_in(tail[k]);
      total++;
      if (y !== exp_y) begin bad++; $display("FAIL cfgpri_tail_y step %0d: got %0b want %0b", 2 - k, y, exp_y); end
    end
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL cfgpri_fresh_match: got %0b want 1", y); end
  endtask

  task automatic test_len_clamp();
    logic [3:0] b0;
    int pulses;
    do_reset();
    load(8'hFF, 4'd0, 1'b1);
    b0 = 4'b1011;
    for (int k = 3; k >= 0; k--) begin
      bit_in(b0[k]);
      total++;
      if (y !== b0[k]) begin bad++; $display("FAIL len0_y step %0d: got %0b want %0b", 3 - k, y, b0[k]); end
    end
    load(8'hFF, 4'd12, 1'b0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      bit_in(1'b1);
      if (y === 1'b1) pulses++;
      total++;
      if (y !== exp_y) begin bad++; $display("FAIL len12_y step %0d: got %0b want %0b", k, y, exp_y); end
    end
    total++;
    if (pulses != 1 || y !== 1'b1) begin bad++; $display("FAIL len12_pulses: got %0d want 1 on last bit", pulses); end
  endtask

  task automatic test_counter();
    do_reset();
    load(8'h01, 4'd1, 1'b1);
    for (int k = 0; k < 5; k++) bit_in(1'b1);
    total++;
    if (match_cnt !== exp_cnt) begin bad++; $display("FAIL cnt_sat: got %0d want %0d", match_cnt, exp_cnt); end
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    total++;
    if (match_cnt !== 2'd0) begin bad++; $display("FAIL cnt_clr_win: got %0d want 0", match_cnt); end
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL cnt_clr_y: got %0b want 1", y); end
    bit_in(1'b1);
    load(8'h02, 4'd2, 1'b0);
    total++;
    if (match_cnt !== exp_cnt) begin bad++; $display("FAIL cnt_keep_on_cfg: got %0d want %0d", match_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset();
    logic [3:0] p;
    p = 4'b1001;
    do_reset();
    for (int k = 3; k >= 0; k--) bit_in(p[k]);
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL arst_pre_y: got %0b want 1", y); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL arst_y: got %0b want 0", y); end
    total++;
    if (match_cnt !== '0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", match_cnt); end
    #2 rst = 1'b0;
    model_reset();
    for (int k = 3; k >= 1; k--) bit_in(p[k]);
    #2 rst = 1'b1;
    #1;
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL arst2_y: got %0b want 0", y); end
    #2 rst = 1'b0;
    model_reset();
    bit_in(1'b1);
    total++;
    if (y !== 1'b0) begin bad++; $display("FAIL arst_nomatch: got %0b want 0", y); end
    for (int k = 3; k >= 0; k--) begin
      bit_in(p[k]);
      total++;
      if (y !== exp_y) begin bad++; $display("FAIL arst_after_y step %0d: got %0b want %0b", 3 - k, y, exp_y); end
    end
    total++;
    if (y !== 1'b1) begin bad++; $display("FAIL arst_full_match: got %0b want 1", y); end
  endtask

  task automatic test_random();
    logic v, b, we, co, clr;
    logic [7:0] cp;
    logic [3:0] cl;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 39) == 0);
      cp  = 8'($urandom);
      cl  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 4));
      co  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 29) == 0);
      cycle(v, b, we, cp, cl, co, clr);
      total++;
      if (y !== exp_y) begin bad++; $display("FAIL rnd_y cyc %0d: got %0b want %0b", n, y, exp_y); end
      total++;
      if (match_cnt !== exp_cnt) begin bad++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", n, match_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_default_1001();
    test_overlap_modes();
    test_gaps();
    test_cfg_priority();
    test_len_clamp();
    test_counter();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
